// File: rtl/gps_sv_sweep_ctrl.sv
// gps_sv_sweep_ctrl: walks the locked GPS code generator through a run of
// satellite numbers. For each SV it waits for the LLKI key, resets the core,
// fires startRound, waits (bounded) for l_code_valid, then hands the captured
// ca/p/l codes to a downstream consumer through a valid/ready handshake.
module gps_sv_sweep_ctrl #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_SV         = 37
) (
    input  logic         sys_clk_50,
    input  logic         sync_rst_in,
    input  logic         cfg_start,
    input  logic         cfg_abort,
    input  logic [5:0]   cfg_first_sv,
    input  logic [5:0]   cfg_num_sv,
    input  logic         key_complete,
    input  logic         l_code_valid,
    input  logic [12:0]  ca_code,
    input  logic [127:0] p_code,
    input  logic [127:0] l_code,
    output logic [5:0]   sv_num,
    output logic         startRound,
    output logic         core_rst,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [5:0]   res_sv,
    output logic [12:0]  res_ca,
    output logic [127:0] res_p,
    output logic [127:0] res_l,
    output logic         busy,
    output logic         done,
    output logic         err_timeout,
    output logic         err_key,
    output logic [5:0]   rounds_done
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_RST_CORE,
        S_START,
        S_WAIT_VALID,
        S_OUTPUT,
        S_FINISH
    } state_t;

    state_t         state_q;
    logic [5:0]     sv_num_q;
    logic           start_round_q;
    logic           core_rst_q;
    logic           res_valid_q;
    logic [5:0]     res_sv_q;
    logic [12:0]    res_ca_q;
    logic [127:0]   res_p_q;
    logic [127:0]   res_l_q;
    logic           busy_q;
    logic           done_q;
    logic           err_timeout_q;
    logic           err_key_q;
    logic [5:0]     rounds_done_q;
    logic [5:0]     remaining_q;
    logic [RCW-1:0] rst_cnt_q;
    logic [TW-1:0]  timer_q;

    // SV numbering is 1-based and wraps from the highest SV back to 1.
    function automatic logic [5:0] next_sv(input logic [5:0] sv);
        return (sv == 6'(MAX_SV)) ? 6'd1 : sv + 6'd1;
    endfunction

    // Sweep sequencer: state, per-round counters, captured result and all
    // registered outputs. Pulsed outputs default low every cycle.
    always_ff @(posedge sys_clk_50) begin
        if (sync_rst_in) begin
            state_q       <= S_IDLE;
            sv_num_q      <= '0;
            start_round_q <= 1'b0;
            core_rst_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_sv_q      <= '0;
            res_ca_q      <= '0;
            res_p_q       <= '0;
            res_l_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_key_q     <= 1'b0;
            rounds_done_q <= '0;
            remaining_q   <= '0;
            rst_cnt_q     <= '0;
            timer_q       <= '0;
        end else begin
            start_round_q <= 1'b0;
            done_q        <= 1'b0;
            core_rst_q    <= 1'b0;
            // Abort wins over everything; FINISH is already on its way out.
            if (cfg_abort && state_q != S_IDLE && state_q != S_FINISH) begin
                state_q     <= S_FINISH;
                res_valid_q <= 1'b0;
                core_rst_q  <= 1'b1;
                done_q      <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cfg_start) begin
                            err_timeout_q <= 1'b0;
                            err_key_q     <= 1'b0;
                            rounds_done_q <= '0;
                            sv_num_q      <= cfg_first_sv;
                            remaining_q   <= cfg_num_sv;
                            busy_q        <= 1'b1;
                            if (cfg_num_sv == 6'd0) begin
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_WAIT_KEY;
                            end
                        end
                    end
                    S_WAIT_KEY: begin
                        if (key_complete) begin
                            state_q    <= S_RST_CORE;
                            core_rst_q <= 1'b1;
                            rst_cnt_q  <= '0;
                        end
                    end
                    S_RST_CORE: begin
                        if (!key_complete) begin
                            err_key_q <= 1'b1;
                            state_q   <= S_FINISH;
                            done_q    <= 1'b1;
                        end else if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                            state_q       <= S_START;
                            start_round_q <= 1'b1;
                        end else begin
                            rst_cnt_q  <= rst_cnt_q + RCW'(1);
                            core_rst_q <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (!key_complete) begin
                            err_key_q <= 1'b1;
                            state_q   <= S_FINISH;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_VALID;
                            timer_q <= '0;
                        end
                    end
                    S_WAIT_VALID: begin
                        // A valid landing on the last timer cycle still counts.
                        if (!key_complete) begin
                            err_key_q <= 1'b1;
                            state_q   <= S_FINISH;
                            done_q    <= 1'b1;
                        end else if (l_code_valid) begin
                            res_sv_q    <= sv_num_q;
                            res_ca_q    <= ca_code;
                            res_p_q     <= p_code;
                            res_l_q     <= l_code;
                            res_valid_q <= 1'b1;
                            state_q     <= S_OUTPUT;
                        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            err_timeout_q <= 1'b1;
                            state_q       <= S_FINISH;
                            done_q        <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    S_OUTPUT: begin
                        // A key drop here still lets the captured result out,
                        // but the sweep ends once it has been taken.
                        if (!key_complete) begin
                            err_key_q <= 1'b1;
                        end
                        if (res_ready) begin
                            res_valid_q   <= 1'b0;
                            rounds_done_q <= rounds_done_q + 6'd1;
                            remaining_q   <= remaining_q - 6'd1;
                            sv_num_q      <= next_sv(sv_num_q);
                            if (remaining_q == 6'd1 || err_key_q || !key_complete) begin
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= S_RST_CORE;
                                core_rst_q <= 1'b1;
                                rst_cnt_q  <= '0;
                            end
                        end
                    end
                    S_FINISH: begin
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sv_num      = sv_num_q;
    assign startRound  = start_round_q;
    assign core_rst    = core_rst_q;
    assign res_valid   = res_valid_q;
    assign res_sv      = res_sv_q;
    assign res_ca      = res_ca_q;
    assign res_p       = res_p_q;
    assign res_l       = res_l_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign err_key     = err_key_q;
    assign rounds_done = rounds_done_q;

endmodule
